// File: rtl/esl_pkg.sv
// Shared constants, FSM state encoding and LFSR tap selection for the ESL
// stream encoder and related stochastic-number blocks.
package esl_pkg;

  localparam int ESL_BIN_LEN    = 8;
  localparam int ESL_STREAM_LEN = (1 << ESL_BIN_LEN) - 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } esl_state_e;

  // Maximal-length Fibonacci tap masks; bit k-1 set for polynomial tap k.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] mask;
    mask = 16'h0000;
    case (width)
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0829;
      13:      mask = 16'h100D;
      14:      mask = 16'h2015;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/esl_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous seed load and step enable.
// A nonzero seed keeps the register out of the all-zero lock-up state.
module esl_lfsr
  import esl_pkg::*;
#(
  parameter int                 WIDTH       = ESL_BIN_LEN,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic feedback;

  assign feedback = ^(value & TAPS);

  // Load has priority over step so a window restart always begins at the seed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/esl_stream_encoder.sv
// Converts one offset-binary bipolar operand per window into an ESL (x, y)
// bitstream of STREAM_LEN live cycles for the processing element.
//
//   state  | meaning
//   IDLE   | no window running; ready for an operand once out of reset
//   STREAM | window in progress; live on every non-stalled cycle
module esl_stream_encoder
  import esl_pkg::*;
#(
  parameter int                   BIN_LEN    = ESL_BIN_LEN,
  parameter int                   STREAM_LEN = (1 << BIN_LEN) - 1,
  parameter logic [BIN_LEN-1:0]   LFSR_SEED  = BIN_LEN'(1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIN_LEN-1:0] in_val,
  input  logic               stall,
  output logic               pe_enable,
  output logic               stream_x,
  output logic               stream_y,
  output logic               window_first,
  output logic               window_last,
  output logic               window_done
);

  localparam int CNT_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

  localparam logic [0:0]       IDLE     = ST_IDLE;
  localparam logic [0:0]       STREAM   = ST_STREAM;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STREAM_LEN - 1);

  logic [0:0]         state;
  logic [BIN_LEN-1:0] op_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_LEN-1:0] lfsr_val;
  logic               rdy_en;
  logic               live;
  logic               last;
  logic               hs;

  assign live         = (state == STREAM) && !stall;
  assign last         = live && (cnt == CNT_LAST);
  assign window_first = live && (cnt == '0);
  assign window_last  = last;

  // in_ready stays low while reset is held and until the first edge after it.
  assign in_ready = (state == IDLE) ? rdy_en : last;
  assign hs       = in_valid && in_ready;

  assign pe_enable = live;
  assign stream_y  = live;
  assign stream_x  = live && (lfsr_val <= op_reg);

  esl_lfsr #(
    .WIDTH       (BIN_LEN),
    .RESET_VALUE (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (hs),
    .step  (live && !hs),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Marks the first clock edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Window FSM: a handshake (re)starts a window, the last live cycle ends it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_reg <= '0;
      cnt    <= '0;
    end else if (hs) begin
      state  <= STREAM;
      op_reg <= in_val;
      cnt    <= '0;
    end else if (live) begin
      if (last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // One-cycle strobe following the last live cycle, regardless of later stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_done <= 1'b0;
    end else begin
      window_done <= last;
    end
  end

endmodule

// File: tb/tb_esl_stream_encoder.sv
// Self-checking bench for esl_stream_encoder: a window-level behavioural
// model predicts every output each cycle; per-window ones-counts and spans
// are pinned against hand-computed values.
module tb_esl_stream_encoder;

  localparam int STREAM_LEN = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_val = 8'h00;
  logic       stall = 1'b0;
  logic       in_ready, pe_enable, stream_x, stream_y;
  logic       window_first, window_last, window_done;

  esl_stream_encoder dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_val       (in_val),
    .stall        (stall),
    .pe_enable    (pe_enable),
    .stream_x     (stream_x),
    .stream_y     (stream_y),
    .window_first (window_first),
    .window_last  (window_last),
    .window_done  (window_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: window in progress, position inside it, latched operand.
  bit m_busy = 0;
  bit m_rdy  = 0;
  bit m_done = 0;
  int m_pos  = 0;
  int m_op   = 0;
  int m_ones = 0;
  int m_span = 0;
  int last_ones = -1;
  int last_span = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic cyc(input bit v, input logic [7:0] val, input bit s);
    bit live, first, last, rdy, hs;
    in_valid = v;
    in_val   = val;
    stall    = s;
    @(negedge clock);
    live  = m_busy && !s;
    first = live && (m_pos == 0);
    last  = live && (m_pos == STREAM_LEN - 1);
    rdy   = m_busy ? last : m_rdy;
    check("pe_enable", {31'd0, pe_enable}, {31'd0, live});
    check("stream_y", {31'd0, stream_y}, {31'd0, live});
    check("window_first", {31'd0, window_first}, {31'd0, first});
    check("window_last", {31'd0, window_last}, {31'd0, last});
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("window_done", {31'd0, window_done}, {31'd0, m_done});
    if (!live) begin
      check("stream_x_quiet", {31'd0, stream_x}, 32'd0);
    end else begin
      if (first) check("stream_x_first", {31'd0, stream_x}, {31'd0, (m_op != 0)});
      if (stream_x === 1'b1) m_ones++;
    end
    if (m_busy) m_span++;
    if (last) begin
      check("ones_count", m_ones, m_op);
      last_ones = m_ones;
      last_span = m_span;
    end
    hs     = v && rdy;
    m_done = last;
    m_rdy  = 1;
    if (hs) begin
      m_busy = 1;
      m_pos  = 0;
      m_op   = val;
      m_ones = 0;
      m_span = 0;
    end else if (live) begin
      if (last) m_busy = 0;
      else m_pos++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = budget;
    while (m_busy && n > 0) begin
      cyc(1'b0, 8'($urandom), 1'b0);
      n--;
    end
    if (m_busy) check("drain_timeout", 32'd1, 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_pe_enable"}, {31'd0, pe_enable}, 32'd0);
    check({tag, "_stream_x"}, {31'd0, stream_x}, 32'd0);
    check({tag, "_stream_y"}, {31'd0, stream_y}, 32'd0);
    check({tag, "_first"}, {31'd0, window_first}, 32'd0);
    check({tag, "_last"}, {31'd0, window_last}, 32'd0);
    check({tag, "_done"}, {31'd0, window_done}, 32'd0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_busy = 0;
    m_done = 0;
    m_rdy  = 0;
    m_ones = 0;
    m_span = 0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1 reset = 1'b1;

    // Single mid-scale window.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h80, 1'b0);
    drain(400);
    check("w80_ones", last_ones, 128);
    check("w80_span", last_span, 255);

    // Back-to-back 0x00 then 0xFF with in_valid held.
    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < STREAM_LEN; i++) cyc(1'b1, 8'hFF, 1'b0);
    check("b2b_first_ones", last_ones, 0);
    check("b2b_second_first", {31'd0, window_first}, 32'd1);
    drain(400);
    check("b2b_second_ones", last_ones, 255);

    // Stall ten cycles in the middle of a 0x40 window.
    cyc(1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    drain(400);
    check("stall_ones", last_ones, 64);
    check("stall_span", last_span, 265);

    // Reset in the middle of a window, then a fresh window.
    cyc(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 99; i++) cyc(1'b0, 8'h00, 1'b0);
    pulse_reset();
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hA5, 1'b0);
    drain(400);
    check("post_reset_ones", last_ones, 165);
    check("post_reset_span", last_span, 255);

    // Acceptance while stalled in IDLE; window waits for stall release.
    cyc(1'b1, 8'h10, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h77, 1'b1);
    drain(400);
    check("idle_stall_ones", last_ones, 16);
    check("idle_stall_span", last_span, 260);

    // Random valid toggling, operand values and occasional stall.
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
